// File: rtl/opa_bias_seq.sv
// Power-up and bias sequencer for the behavioural op-amp: ramps the bias current
// to a trimmed target, settles, enables the op-amp, and forces a safe state on supply loss.
module opa_bias_seq #(
    parameter real IB_NOM      = 500.0e-9,
    parameter real IB_TRIM_LSB = 10.0e-9,
    parameter real IB_STEP     = 50.0e-9,
    parameter int  SETTLE_CYC  = 16,
    parameter real P_VT_3P3V   = 1.75,
    parameter real P_VT_VSS    = 0.1
) (
    input  logic       clk_i_3P3V,
    input  logic       rstn_i_3P3V,
    input  real        AVDD_3P3V,
    input  real        AVSS,
    input  real        PBKG,
    input  logic       pwr_up_req_i_3P3V,
    input  logic       rdcpwr_req_i_3P3V,
    input  logic [3:0] ib_trim_i_3P3V,
    output real        ibopa_up_0p5uA_a_3P3V,
    output logic       en_o_3P3V,
    output logic       rdcpwr_o_3P3V,
    output logic       ready_o_3P3V,
    output logic       fault_o_3P3V,
    output logic [2:0] state_dbg
);

    // Current is tracked as an integer count of nA; the analog output is derived from it.
    localparam int NOM_NA  = int'(IB_NOM * 1.0e9);
    localparam int TRIM_NA = int'(IB_TRIM_LSB * 1.0e9);
    localparam int STEP_NA = int'(IB_STEP * 1.0e9);
    localparam int IW      = 10;
    localparam int CW      = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        OFF     = 3'd0,
        RAMP_UP = 3'd1,
        SETTLE  = 3'd2,
        ACTIVE  = 3'd3,
        RAMP_DN = 3'd4,
        FAULT   = 3'd5
    } state_t;

    state_t        state;
    logic [IW-1:0] ib_na;
    logic [IW-1:0] ib_tgt;
    logic [CW-1:0] cnt;
    logic          supply_ok;
    logic [IW-1:0] tgt_next;
    logic [IW:0]   ib_up;
    int            tgt_calc;

    // A non-numeric supply compares false, so it is treated as not ok.
    always_comb begin
        supply_ok = (AVDD_3P3V > P_VT_3P3V) && (AVSS < P_VT_VSS) && (PBKG < P_VT_VSS);
    end

    always_comb begin
        tgt_calc = NOM_NA + int'($signed(ib_trim_i_3P3V)) * TRIM_NA;
        tgt_next = IW'(tgt_calc);
        ib_up    = {1'b0, ib_na} + (IW+1)'(STEP_NA);
    end

    assign ibopa_up_0p5uA_a_3P3V = real'(ib_na) * 1.0e-9;
    assign state_dbg             = state;

    always_ff @(posedge clk_i_3P3V or negedge rstn_i_3P3V) begin
        if (!rstn_i_3P3V) begin
            state         <= OFF;
            ib_na         <= '0;
            ib_tgt        <= '0;
            cnt           <= '0;
            en_o_3P3V     <= 1'b0;
            rdcpwr_o_3P3V <= 1'b0;
            ready_o_3P3V  <= 1'b0;
            fault_o_3P3V  <= 1'b0;
        end else if (state != OFF && !supply_ok) begin
            // Supply loss overrides every other transition and drops bias at once.
            state         <= FAULT;
            ib_na         <= '0;
            en_o_3P3V     <= 1'b0;
            rdcpwr_o_3P3V <= 1'b0;
            ready_o_3P3V  <= 1'b0;
            fault_o_3P3V  <= 1'b1;
        end else begin
            case (state)
                OFF: begin
                    ib_na         <= '0;
                    en_o_3P3V     <= 1'b0;
                    ready_o_3P3V  <= 1'b0;
                    rdcpwr_o_3P3V <= 1'b0;
                    if (pwr_up_req_i_3P3V && supply_ok) begin
                        ib_tgt <= tgt_next;
                        state  <= RAMP_UP;
                    end
                end
                RAMP_UP: begin
                    if (!pwr_up_req_i_3P3V) begin
                        state <= (ib_na <= IW'(STEP_NA)) ? OFF : RAMP_DN;
                        ib_na <= (ib_na <= IW'(STEP_NA)) ? '0 : ib_na - IW'(STEP_NA);
                    end else if (ib_up >= {1'b0, ib_tgt}) begin
                        ib_na <= ib_tgt;
                        cnt   <= '0;
                        state <= SETTLE;
                    end else begin
                        ib_na <= ib_up[IW-1:0];
                    end
                end
                SETTLE: begin
                    if (!pwr_up_req_i_3P3V) begin
                        state <= (ib_na <= IW'(STEP_NA)) ? OFF : RAMP_DN;
                        ib_na <= (ib_na <= IW'(STEP_NA)) ? '0 : ib_na - IW'(STEP_NA);
                    end else if (cnt == CNT_LAST) begin
                        state        <= ACTIVE;
                        en_o_3P3V    <= 1'b1;
                        ready_o_3P3V <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ACTIVE: begin
                    if (!pwr_up_req_i_3P3V) begin
                        state         <= (ib_na <= IW'(STEP_NA)) ? OFF : RAMP_DN;
                        ib_na         <= (ib_na <= IW'(STEP_NA)) ? '0 : ib_na - IW'(STEP_NA);
                        en_o_3P3V     <= 1'b0;
                        ready_o_3P3V  <= 1'b0;
                        rdcpwr_o_3P3V <= 1'b0;
                    end else begin
                        rdcpwr_o_3P3V <= rdcpwr_req_i_3P3V;
                    end
                end
                RAMP_DN: begin
                    // Re-request resumes from the present current with the trim already held.
                    if (pwr_up_req_i_3P3V) begin
                        state <= RAMP_UP;
                    end else if (ib_na <= IW'(STEP_NA)) begin
                        ib_na <= '0;
                        state <= OFF;
                    end else begin
                        ib_na <= ib_na - IW'(STEP_NA);
                    end
                end
                FAULT: begin
                    ib_na <= '0;
                    if (!pwr_up_req_i_3P3V) begin
                        state        <= OFF;
                        fault_o_3P3V <= 1'b0;
                    end
                end
                default: begin
                    state <= OFF;
                    ib_na <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_opa_bias_seq.sv
// Directed bench for opa_bias_seq: ramp, settle, enable, ramp-down, fault and
// asynchronous reset sequences, with bias current checked in nA.
module tb_opa_bias_seq;

    logic       clk;
    logic       rstn;
    real        avdd;
    real        avss;
    real        pbkg;
    logic       req;
    logic       rdc_req;
    logic [3:0] trim;
    real        ib;
    logic       en;
    logic       rdcpwr;
    logic       ready;
    logic       fault;
    logic [2:0] state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    localparam int S_OFF = 0, S_UP = 1, S_SET = 2, S_ACT = 3, S_DN = 4, S_FLT = 5;

    opa_bias_seq dut (
        .clk_i_3P3V            (clk),
        .rstn_i_3P3V           (rstn),
        .AVDD_3P3V             (avdd),
        .AVSS                  (avss),
        .PBKG                  (pbkg),
        .pwr_up_req_i_3P3V     (req),
        .rdcpwr_req_i_3P3V     (rdc_req),
        .ib_trim_i_3P3V        (trim),
        .ibopa_up_0p5uA_a_3P3V (ib),
        .en_o_3P3V             (en),
        .rdcpwr_o_3P3V         (rdcpwr),
        .ready_o_3P3V          (ready),
        .fault_o_3P3V          (fault),
        .state_dbg             (state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int ib_na_of(input real r);
        return $rtoi(r * 1.0e9 + 0.5);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_outs(input string tag, input int e_ib, input int e_en,
                            input int e_fault, input int e_state);
        chk({tag, "_ib"}, ib_na_of(ib), e_ib);
        chk({tag, "_en"}, int'(en), e_en);
        chk({tag, "_ready"}, int'(ready), e_en);
        chk({tag, "_fault"}, int'(fault), e_fault);
        chk({tag, "_state"}, int'(state_dbg), e_state);
    endtask

    task automatic wait_state(input int st, input int budget);
        int n = 0;
        while (int'(state_dbg) != st && n < budget) begin
            tick();
            n++;
        end
        chk("wait_state", int'(state_dbg), st);
    endtask

    initial begin
        rstn    = 1'b0;
        avdd    = 3.0;
        avss    = 0.0;
        pbkg    = 0.0;
        req     = 1'b1;
        rdc_req = 1'b0;
        trim    = 4'd0;
        #1;
        chk_outs("reset", 0, 0, 0, S_OFF);
        chk("reset_rdcpwr", int'(rdcpwr), 0);
        @(negedge clk);
        rstn = 1'b1;

        // Nominal power-up: edge 0 leaves OFF, 10 ramp edges, enable at edge 26.
        tick();
        chk_outs("e0", 0, 0, 0, S_UP);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("ramp_nom_ib", ib_na_of(ib), 50 * k);
        end
        chk("ramp_done_state", int'(state_dbg), S_SET);
        repeat (15) tick();
        chk("e25_en", int'(en), 0);
        tick();
        chk_outs("e26", 500, 1, 0, S_ACT);
        chk("e26_rdcpwr", int'(rdcpwr), 0);
        rdc_req = 1'b1;
        tick();
        chk("rdcpwr_follow1", int'(rdcpwr), 1);
        rdc_req = 1'b0;
        tick();
        chk("rdcpwr_follow0", int'(rdcpwr), 0);

        // Ramp down with reduced-power still requested: forced low on exit.
        rdc_req = 1'b1;
        tick();
        chk("rdcpwr_set", int'(rdcpwr), 1);
        req = 1'b0;
        tick();
        chk_outs("dn1", 450, 0, 0, S_DN);
        chk("dn1_rdcpwr", int'(rdcpwr), 0);
        rdc_req = 1'b0;
        for (int n = 2; n <= 10; n++) begin
            tick();
            chk("ramp_dn_ib", ib_na_of(ib), 500 - 50 * n);
        end
        chk("dn_off_state", int'(state_dbg), S_OFF);

        // Re-request during ramp-down resumes from 200 nA.
        req = 1'b1;
        tick();
        repeat (10) tick();
        repeat (16) tick();
        chk_outs("reup_act", 500, 1, 0, S_ACT);
        req = 1'b0;
        repeat (6) tick();
        chk_outs("dn_200", 200, 0, 0, S_DN);
        req = 1'b1;
        tick();
        chk_outs("resume", 200, 0, 0, S_UP);
        tick();
        chk("resume_step", ib_na_of(ib), 250);
        repeat (5) tick();
        chk_outs("resume_top", 500, 0, 0, S_SET);
        repeat (16) tick();
        chk_outs("resume_act", 500, 1, 0, S_ACT);

        // Supply fault from ACTIVE, held while requested, cleared on request drop.
        avdd = 1.5;
        tick();
        chk_outs("fault_in", 0, 0, 1, S_FLT);
        chk("fault_rdcpwr", int'(rdcpwr), 0);
        avdd = 3.0;
        tick();
        chk_outs("fault_hold", 0, 0, 1, S_FLT);
        req = 1'b0;
        tick();
        chk_outs("fault_clr", 0, 0, 0, S_OFF);
        avdd = 1.5;
        req  = 1'b1;
        tick();
        chk_outs("off_badsup", 0, 0, 0, S_OFF);
        avdd = 3.0;
        avss = 0.3;
        tick();
        chk_outs("off_badvss", 0, 0, 0, S_OFF);
        avss = 0.0;

        // Trim +4: 540 nA over 11 edges; trim change mid-ramp is ignored.
        trim = 4'd4;
        tick();
        chk("t4_state", int'(state_dbg), S_UP);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("t4_ib", ib_na_of(ib), 50 * k);
            if (k == 5) trim = 4'b1000;
        end
        tick();
        chk_outs("t4_top", 540, 0, 0, S_SET);
        repeat (16) tick();
        chk_outs("t4_act", 540, 1, 0, S_ACT);
        req = 1'b0;
        wait_state(S_OFF, 20);
        chk("t4_off_ib", ib_na_of(ib), 0);

        // Trim -8: 420 nA reached on edge 9 with a 20 nA clamped step.
        trim = 4'b1000;
        req  = 1'b1;
        tick();
        repeat (8) tick();
        chk("tm8_ib8", ib_na_of(ib), 400);
        tick();
        chk_outs("tm8_top", 420, 0, 0, S_SET);
        repeat (5) tick();
        chk("mid_settle_state", int'(state_dbg), S_SET);

        // Asynchronous reset mid-SETTLE takes effect between clock edges.
        #2;
        rstn = 1'b0;
        #1;
        chk_outs("async_rst", 0, 0, 0, S_OFF);
        chk("async_rst_rdcpwr", int'(rdcpwr), 0);
        @(negedge clk);
        trim = 4'd7;
        rstn = 1'b1;
        tick();
        chk_outs("rst_restart", 0, 0, 0, S_UP);
        repeat (11) tick();
        chk("t7_ib11", ib_na_of(ib), 550);
        tick();
        chk_outs("t7_top", 570, 0, 0, S_SET);
        repeat (16) tick();
        chk_outs("t7_act", 570, 1, 0, S_ACT);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/opa_bias_seq.md
Name: opa_bias_seq

Overview:
- Upstream power-up and bias sequencer for the behavioural op-amp core.
- Generates the op-amp bias current `ibopa_up_0p5uA_a_3P3V` as a wreal.
- Ramps that current to a trimmed target, waits a settle interval, then drives the op-amp enable and reduced-power controls.
- Monitors the analog supplies and forces a safe state on a supply fault.

Parameters:
- IB_NOM, 500.0e-9, nominal bias target in A.
- IB_TRIM_LSB, 10.0e-9, trim step in A per LSB of the signed trim code.
- IB_STEP, 50.0e-9, ramp increment/decrement per clock in A.
- SETTLE_CYC, 16, clocks held at target before enable.
- P_VT_3P3V, 1.75, AVDD good threshold in V.
- P_VT_VSS, 0.1, AVSS/PBKG good threshold in V.

Ports:
- clk_i_3P3V  in  1  sequencer clock, nominal 100 MHz.
- rstn_i_3P3V  in  1  reset. One clock; reset is asynchronous and active-low.
- AVDD_3P3V  in  wreal  analog supply.
- AVSS  in  wreal  analog ground.
- PBKG  in  wreal  substrate.
- pwr_up_req_i_3P3V  in  1  request op-amp on (1) or off (0).
- rdcpwr_req_i_3P3V  in  1  request reduced-power mode.
- ib_trim_i_3P3V  in  4  two's-complement trim, -8..+7.
- ibopa_up_0p5uA_a_3P3V  out  wreal  bias current to the op-amp, in A.
- en_o_3P3V  out  1  op-amp enable.
- rdcpwr_o_3P3V  out  1  op-amp reduced-power select.
- ready_o_3P3V  out  1  op-amp enabled and biased.
- fault_o_3P3V  out  1  supply fault latched.

Behaviour:
- Reset (rstn low, asynchronous):
  - state=OFF, ib=0.0, all 1-bit outputs 0, settle counter 0.
  - Outputs hold these values while reset is low.
- supply_ok (combinational): AVDD>P_VT_3P3V && AVSS<P_VT_VSS && PBKG<P_VT_VSS. X/Z on any supply counts as not ok.
- Target: ib_tgt = IB_NOM + signed(ib_trim)*IB_TRIM_LSB, giving a range of 420..570 nA. Trim is latched on the OFF->RAMP_UP edge; later trim changes are ignored until the next OFF.
- All transitions occur on the posedge of clk_i_3P3V.
- OFF:
  - ib=0, en=0.
  - If pwr_up_req && supply_ok: latch trim, go to RAMP_UP.
- RAMP_UP:
  - Each edge: ib = min(ib+IB_STEP, ib_tgt).
  - On the edge where ib reaches ib_tgt: clear counter, go to SETTLE.
  - Ramp length is ceil(ib_tgt/IB_STEP) edges; the last step clamps to the target.
- SETTLE:
  - Counter increments each edge.
  - When counter reaches SETTLE_CYC-1: go to ACTIVE and set en=1 and ready=1 on that same edge.
  - Net: en rises SETTLE_CYC edges after the ramp-complete edge.
- ACTIVE:
  - en=1, ready=1.
  - rdcpwr_o <= rdcpwr_req each edge. rdcpwr_o is forced to 0 in every other state.
- RAMP_DN:
  - Entered from RAMP_UP, SETTLE or ACTIVE when pwr_up_req=0.
  - On the entry edge: en=0, ready=0, rdcpwr_o=0.
  - Each edge: ib = max(ib-IB_STEP, 0.0). Go to OFF on the edge ib reaches 0.
  - If pwr_up_req reasserts during RAMP_DN: go to RAMP_UP from the current ib. Trim is not re-latched.
- FAULT:
  - Entered from any state except OFF when supply_ok=0 at an edge. This has priority over every other transition.
  - On the entry edge: ib=0.0 (no ramp), en=0, ready=0, rdcpwr_o=0, fault=1.
  - Leave to OFF only when pwr_up_req=0 && supply_ok=1; fault clears on that edge.
- supply_ok=0 while in OFF: stay in OFF, fault stays 0.
- Simultaneous supply fault and pwr_up_req drop: FAULT wins.
- Output ib is a real value, never Z/X. The op-amp window check (400–600 nA) therefore fails cleanly while ramping.
- Invariant: en_o_3P3V=1 implies ib == ib_tgt and state==ACTIVE.

Test Plan:
- Reset, AVDD=3.0, trim=0, req=1 at edge 0 -> ib steps 50 nA per edge to 500 nA at edge 10; en and ready rise at edge 26; rdcpwr_o follows rdcpwr_req one edge later.
- trim=+4 -> target 540 nA; 11 ramp edges, last step 40 nA; trim changed to -8 mid-ramp is ignored, final ib=540 nA.
- ACTIVE, then req=0 -> en and ready fall on the next edge; ib decreases 500→0 over 10 edges; state OFF. Reassert req at ib=200 nA -> ramps back up from 200 nA.
- ACTIVE, then AVDD drops to 1.5 V -> the next edge gives ib=0, en=0, fault=1. Restore AVDD with req=1 -> stays FAULT. Drop req -> OFF, fault=0.
- Assert rstn low asynchronously mid-SETTLE -> all outputs 0 and ib=0.0 immediately. Release with req=1 -> full sequence restarts from 0 nA.
- trim=-8 and trim=+7 -> targets of 420 nA and 570 nA reached exactly, each inside the op-amp 400–600 nA window.
